bidsn_auction: RTL and testbench
================================

// Module: bidsn_auction
// PURPOSE
//  N-bidder sealed-bid auction controller. Parametrised successor of the 3-bidder controller.
//  Key lock/cooldown, per-bidder balances, per-bid charge, ordered tie-break, registered ack/err.
//  Sits between the auctioneer control port and N bidder ports in the bids top level.
// PARAMETERS
//  DATAWIDTH   32  width of balances, bids, key, timer, charge
//  NUMBIDDERS  3   bidder count, 2..16
//  IDXW        $clog2(NUMBIDDERS)  width of the bidder index field (derived)
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  c_op         in   4           opcode (bidsn_pkg::op_t)
//  c_data       in   DATAWIDTH   operand for c_op
//  c_idx        in   IDXW        bidder index for LOAD
//  c_start      in   1           high for the whole round
//  c_ready      out  1           controller accepts c_op
//  c_err        out  3           controller error (bidsn_pkg::cerr_t)
//  c_roundover  out  1           one-cycle pulse at resolve
//  c_maxbid     out  DATAWIDTH   current/final max bid
//  bid_vld      in   NUMBIDDERS  per-bidder bid request
//  bid_amt      in   NUMBIDDERS*DATAWIDTH  packed bid amounts, bidder i at [i*DW +: DW]
//  retract      in   NUMBIDDERS  withdraw own standing bid
//  bid_ack      out  NUMBIDDERS  bid accepted, registered
//  bid_err      out  NUMBIDDERS*2  per-bidder error (bidsn_pkg::berr_t), registered
//  bid_win      out  NUMBIDDERS  one-hot winner, held until next round start
//  balance      out  NUMBIDDERS*DATAWIDTH  current balances
// BEHAVIOUR
//  Reset values:
//   - state=UNLOCKED, balances/lastbid/key=0, mask=all-ones, timer=15, charge=1.
//   - All outputs 0 except c_ready=1.
//  UNLOCKED:
//   - LOCK stores key -> LOCKED. LOAD writes balance[c_idx]; c_idx>=N -> c_err=BADINDEX, no write.
//   - SETMASK, SETTIMER, SETBIDCHARGE load their registers.
//   - UNLOCK -> ALREADYUNLOCKED. Undefined op -> INVALID_OP.
//   - c_start -> CSTARTUNLOCKED, state unchanged. c_err is combinational, valid the same cycle.
//  LOCKED:
//   - c_start -> ROUND. UNLOCK with matching key -> UNLOCKED.
//   - Mismatched key -> COOLDOWN, counter=timer.
//  COOLDOWN:
//   - c_err=BADKEY. Counter decrements each cycle; at 0 -> LOCKED. Timer=0 gives one cycle.
//   - All ops are ignored.
//  ROUND:
//   - Bid i is accepted iff mask[i], and bid_amt+charge <= balance[i] computed at DATAWIDTH+1 bits.
//   - Accept: balance-=charge, lastbid[i]=bid_amt, ack=1, err=NOBIDERR, registered (1-cycle latency).
//   - Reject: MASKED or NOFUNDS, ack=0.
//   - retract clears lastbid[i], no refund. bid and retract in the same cycle: bid wins.
//   - Leader register is updated only when an accepted bid is strictly greater than the current max.
//   - Equal bids: the earlier accepted one keeps the lead. Same cycle: lowest index wins.
//   - Retract of the leader re-evaluates max over the remaining lastbid values; ties go to lowest index.
//   - c_maxbid tracks the leader amount. c_start low -> RESOLVE.
//  RESOLVE (1 cycle):
//   - c_ready=0, c_roundover=1. Leader's balance-=lastbid, bid_win[leader]=1.
//   - No standing bids: no winner, c_maxbid=0. Clear lastbid -> LOCKED.
//   - bid_win and c_maxbid are held until the next ROUND entry.
//  bid_vld outside ROUND: bid_err=INACTIVE, ack=0, no state change.
//  Balance arithmetic never wraps, guaranteed by the acceptance check.
//  reset_n low mid-round: immediate full reset, charges not refunded, no winner.
// STRUCTURE
//  bidsn_pkg:
//   - op_t {NO_OP, UNLOCK, LOCK, LOAD, SETMASK, SETTIMER, SETBIDCHARGE}
//   - cerr_t {NOERROR, BADINDEX, ALREADYUNLOCKED, INVALID_OP, CSTARTUNLOCKED, BADKEY}
//   - berr_t {NOBIDERR, INACTIVE, MASKED, NOFUNDS}
//   - state_t {UNLOCKED, LOCKED, COOLDOWN, ROUND, RESOLVE}
//  Sub-module bidsn_argmax: combinational max/argmax over NUMBIDDERS values with valid mask.
//   Lowest index wins ties. Used for the same-cycle leader and retract re-evaluation.
// TESTING
//  1 Reset, LOAD idx0..2=100,50,20, LOCK 0xA5, c_start: bids 30/30/10 same cycle
//    -> acks 1/1/1, leader idx0, c_maxbid=30; end -> win=001, balance0=100-1-30=69.
//  2 Idx1 bids 40, then idx0 bids 40 -> leader stays idx1, win=010.
//  3 Balance 20, charge 1, bid 20 -> NOFUNDS, ack 0; bid 19 -> ack 1 (exact boundary).
//  4 UNLOCK 0x5A with key 0xA5, timer 3 -> BADKEY for 3 cycles, then LOCKED; UNLOCK 0xA5 -> UNLOCKED.
//  5 Leader retracts -> next highest bidder leads, c_maxbid updates; all retract -> no winner, maxbid 0.
//  6 reset_n low mid-ROUND -> all outputs at reset values the same cycle; NUMBIDDERS=8 rerun of 1.

Source files
------------

// File: rtl/bidsn_pkg.sv
// rtl/bidsn_pkg.sv - shared opcodes, error codes and states for the sealed-bid auction
package bidsn_pkg;

  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    UNLOCK       = 4'd1,
    LOCK         = 4'd2,
    LOAD         = 4'd3,
    SETMASK      = 4'd4,
    SETTIMER     = 4'd5,
    SETBIDCHARGE = 4'd6
  } op_t;

  typedef enum logic [2:0] {
    NOERROR         = 3'd0,
    BADINDEX        = 3'd1,
    ALREADYUNLOCKED = 3'd2,
    INVALID_OP      = 3'd3,
    CSTARTUNLOCKED  = 3'd4,
    BADKEY          = 3'd5
  } cerr_t;

  typedef enum logic [1:0] {
    NOBIDERR = 2'd0,
    INACTIVE = 2'd1,
    MASKED   = 2'd2,
    NOFUNDS  = 2'd3
  } berr_t;

  typedef enum logic [2:0] {
    UNLOCKED = 3'd0,
    LOCKED   = 3'd1,
    COOLDOWN = 3'd2,
    ROUND    = 3'd3,
    RESOLVE  = 3'd4
  } state_t;

  localparam int TIMER_RST  = 15;
  localparam int CHARGE_RST = 1;

endpackage

// File: rtl/bidsn_argmax.sv
// rtl/bidsn_argmax.sv - combinational max/argmax over masked values, lowest index wins ties
module bidsn_argmax
  import bidsn_pkg::*;
#(
  parameter int DW   = 32,
  parameter int N    = 3,
  parameter int IDXW = 2
) (
  input  logic [N*DW-1:0] vals,
  input  logic [N-1:0]    vld,
  output logic            any_vld,
  output logic [DW-1:0]   max_val,
  output logic [IDXW-1:0] max_idx
);

  // strict compare keeps the earliest (lowest) index on equal values
  always_comb begin
    any_vld = 1'b0;
    max_val = '0;
    max_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vld[i] && (!any_vld || vals[i*DW +: DW] > max_val)) begin
        any_vld = 1'b1;
        max_val = vals[i*DW +: DW];
        max_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/bidsn_auction.sv
// rtl/bidsn_auction.sv - N-bidder sealed-bid auction controller with key lock and cooldown
module bidsn_auction
  import bidsn_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int IDXW       = $clog2(NUMBIDDERS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [3:0]                     c_op,
  input  logic [DATAWIDTH-1:0]           c_data,
  input  logic [IDXW-1:0]                c_idx,
  input  logic                           c_start,
  output logic                           c_ready,
  output logic [2:0]                     c_err,
  output logic                           c_roundover,
  output logic [DATAWIDTH-1:0]           c_maxbid,
  input  logic [NUMBIDDERS-1:0]          bid_vld,
  input  logic [NUMBIDDERS*DATAWIDTH-1:0] bid_amt,
  input  logic [NUMBIDDERS-1:0]          retract,
  output logic [NUMBIDDERS-1:0]          bid_ack,
  output logic [NUMBIDDERS*2-1:0]        bid_err,
  output logic [NUMBIDDERS-1:0]          bid_win,
  output logic [NUMBIDDERS*DATAWIDTH-1:0] balance
);

  localparam int DW = DATAWIDTH;
  localparam int N  = NUMBIDDERS;

  state_t          state, state_nxt;
  cerr_t           err;
  logic [DW-1:0]   key, timer, charge, cnt, maxbid;
  logic [N-1:0]    mask, stand, nstand, acc, ret_eff;
  logic [DW-1:0]   bal     [N];
  logic [DW-1:0]   lastbid [N];
  berr_t           berr    [N];
  logic [N*DW-1:0] nlast_flat;
  logic            leader_vld, leader_ret;
  logic [IDXW-1:0] leader;
  logic            a_any, r_any;
  logic [DW-1:0]   a_max, r_max;
  logic [IDXW-1:0] a_idx, r_idx;
  logic            wr_key, wr_bal, wr_mask, wr_timer, wr_charge, ld_cnt;

  // per-bidder acceptance and the standing-bid picture after this cycle
  always_comb begin
    acc        = '0;
    ret_eff    = '0;
    nstand     = stand;
    nlast_flat = '0;
    for (int i = 0; i < N; i++) begin
      berr[i] = NOBIDERR;
      if (bid_vld[i]) begin
        if (state != ROUND)
          berr[i] = INACTIVE;
        else if (!mask[i])
          berr[i] = MASKED;
        else if ({1'b0, bid_amt[i*DW +: DW]} + {1'b0, charge} > {1'b0, bal[i]})
          berr[i] = NOFUNDS;
        else
          acc[i] = 1'b1;
      end
      ret_eff[i] = (state == ROUND) && retract[i] && !acc[i];
      nstand[i]  = acc[i] | (stand[i] & ~ret_eff[i]);
      nlast_flat[i*DW +: DW] = acc[i] ? bid_amt[i*DW +: DW] :
                               (ret_eff[i] ? '0 : lastbid[i]);
    end
  end

  assign leader_ret = leader_vld && ret_eff[leader];

  bidsn_argmax #(.DW(DW), .N(N), .IDXW(IDXW)) u_acc_max (
    .vals    (bid_amt),
    .vld     (acc),
    .any_vld (a_any),
    .max_val (a_max),
    .max_idx (a_idx)
  );

  bidsn_argmax #(.DW(DW), .N(N), .IDXW(IDXW)) u_ret_max (
    .vals    (nlast_flat),
    .vld     (nstand),
    .any_vld (r_any),
    .max_val (r_max),
    .max_idx (r_idx)
  );

  always_comb begin
    state_nxt = state;
    err       = NOERROR;
    wr_key    = 1'b0;
    wr_bal    = 1'b0;
    wr_mask   = 1'b0;
    wr_timer  = 1'b0;
    wr_charge = 1'b0;
    ld_cnt    = 1'b0;
    case (state)
      UNLOCKED: begin
        if (c_start) begin
          err = CSTARTUNLOCKED;
        end else begin
          case (op_t'(c_op))
            NO_OP:        ;
            UNLOCK:       err = ALREADYUNLOCKED;
            LOCK: begin
              wr_key    = 1'b1;
              state_nxt = LOCKED;
            end
            LOAD: begin
              if (int'(c_idx) >= N) err = BADINDEX;
              else                  wr_bal = 1'b1;
            end
            SETMASK:      wr_mask   = 1'b1;
            SETTIMER:     wr_timer  = 1'b1;
            SETBIDCHARGE: wr_charge = 1'b1;
            default:      err = INVALID_OP;
          endcase
        end
      end
      LOCKED: begin
        if (c_start) begin
          state_nxt = ROUND;
        end else if (op_t'(c_op) == UNLOCK) begin
          if (c_data == key) begin
            state_nxt = UNLOCKED;
          end else begin
            state_nxt = COOLDOWN;
            ld_cnt    = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        // a zero timer still costs one cycle
        err = BADKEY;
        if (cnt <= DW'(1)) state_nxt = LOCKED;
      end
      ROUND:   if (!c_start) state_nxt = RESOLVE;
      RESOLVE: state_nxt = LOCKED;
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNLOCKED;
      key        <= '0;
      timer      <= DW'(TIMER_RST);
      charge     <= DW'(CHARGE_RST);
      cnt        <= '0;
      maxbid     <= '0;
      mask       <= '1;
      stand      <= '0;
      leader_vld <= 1'b0;
      leader     <= '0;
      bid_ack    <= '0;
      bid_err    <= '0;
      bid_win    <= '0;
      for (int i = 0; i < N; i++) begin
        bal[i]     <= '0;
        lastbid[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      bid_ack <= acc;
      for (int i = 0; i < N; i++) bid_err[2*i +: 2] <= berr[i];
      if (wr_key)    key    <= c_data;
      if (wr_mask)   mask   <= c_data[N-1:0];
      if (wr_timer)  timer  <= c_data;
      if (wr_charge) charge <= c_data;
      if (ld_cnt)
        cnt <= timer;
      else if (state == COOLDOWN && cnt != '0)
        cnt <= cnt - DW'(1);
      for (int i = 0; i < N; i++)
        if (wr_bal && c_idx == IDXW'(i)) bal[i] <= c_data;

      case (state)
        LOCKED: begin
          if (state_nxt == ROUND) begin
            bid_win    <= '0;
            maxbid     <= '0;
            leader_vld <= 1'b0;
          end
        end
        ROUND: begin
          stand <= nstand;
          for (int i = 0; i < N; i++) begin
            lastbid[i] <= nlast_flat[i*DW +: DW];
            if (acc[i]) bal[i] <= bal[i] - charge;
          end
          // a retracting leader forces a rescan; otherwise only a strictly higher bid takes over
          if (leader_ret) begin
            leader_vld <= r_any;
            leader     <= r_idx;
            maxbid     <= r_max;
          end else if (a_any && (!leader_vld || a_max > maxbid)) begin
            leader_vld <= 1'b1;
            leader     <= a_idx;
            maxbid     <= a_max;
          end
        end
        RESOLVE: begin
          for (int i = 0; i < N; i++) begin
            if (leader_vld && leader == IDXW'(i)) begin
              bal[i]     <= bal[i] - lastbid[i];
              bid_win[i] <= 1'b1;
            end
            lastbid[i] <= '0;
          end
          if (!leader_vld) maxbid <= '0;
          stand      <= '0;
          leader_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign c_err       = reset_n ? err : NOERROR;
  assign c_ready     = (state != RESOLVE);
  assign c_roundover = (state == RESOLVE);
  assign c_maxbid    = maxbid;

  always_comb begin
    balance = '0;
    for (int i = 0; i < N; i++) balance[i*DW +: DW] = bal[i];
  end

endmodule

// File: tb/tb_bidsn_auction.sv
// tb/tb_bidsn_auction.sv - self-checking bench for bidsn_auction (N=3 and N=8)
module tb_bidsn_auction;
  import bidsn_pkg::*;

  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [3:0]      c_op;
  logic [DW-1:0]   c_data;
  logic [1:0]      c_idx;
  logic            c_start, c_ready, c_roundover;
  logic [2:0]      c_err;
  logic [DW-1:0]   c_maxbid;
  logic [N-1:0]    bid_vld, retract, bid_ack, bid_win;
  logic [N*DW-1:0] bid_amt, balance;
  logic [2*N-1:0]  bid_err;

  logic [3:0]      op8;
  logic [DW-1:0]   data8, maxbid8;
  logic [2:0]      idx8, err8;
  logic            start8, ready8, over8;
  logic [7:0]      bv8, rt8, ack8, win8;
  logic [8*DW-1:0] ba8, bal8;
  logic [15:0]     berr8;

  bidsn_auction #(.DATAWIDTH(DW), .NUMBIDDERS(N)) dut (
    .clk(clk), .reset_n(reset_n), .c_op(c_op), .c_data(c_data), .c_idx(c_idx),
    .c_start(c_start), .c_ready(c_ready), .c_err(c_err), .c_roundover(c_roundover),
    .c_maxbid(c_maxbid), .bid_vld(bid_vld), .bid_amt(bid_amt), .retract(retract),
    .bid_ack(bid_ack), .bid_err(bid_err), .bid_win(bid_win), .balance(balance)
  );

  bidsn_auction #(.DATAWIDTH(DW), .NUMBIDDERS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .c_op(op8), .c_data(data8), .c_idx(idx8),
    .c_start(start8), .c_ready(ready8), .c_err(err8), .c_roundover(over8),
    .c_maxbid(maxbid8), .bid_vld(bv8), .bid_amt(ba8), .retract(rt8),
    .bid_ack(ack8), .bid_err(berr8), .bid_win(win8), .balance(bal8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [DW-1:0] d, input logic [1:0] ix);
    c_op = op; c_data = d; c_idx = ix;
    tick();
    c_op = NO_OP; c_data = '0; c_idx = '0;
  endtask

  task automatic cmd8(input logic [3:0] op, input logic [DW-1:0] d, input logic [2:0] ix);
    op8 = op; data8 = d; idx8 = ix;
    tick();
    op8 = NO_OP; data8 = '0; idx8 = '0;
  endtask

  function automatic logic [DW-1:0] bal_of(input int i);
    logic [N*DW-1:0] b;
    b = balance;
    return b[i*DW +: DW];
  endfunction

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] data;
    logic [1:0]    idx;
    logic          start;
    logic [2:0]    err;
  } vec_t;
  vec_t tbl[9];

  // behavioural model state for the randomized rounds
  int unsigned m_bal[N], m_last[N], amt[N];
  bit          m_stand[N], v[N], rt[N];
  bit          m_lvld, retlead;
  int          m_lead;
  int unsigned m_max, m_charge;
  logic [N-1:0]   m_mask, e_ack, e_win;
  logic [2*N-1:0] e_err;

  initial begin
    tbl[0] = '{NO_OP,        32'd0,  2'd0, 1'b0, NOERROR};
    tbl[1] = '{UNLOCK,       32'd0,  2'd0, 1'b0, ALREADYUNLOCKED};
    tbl[2] = '{LOAD,         32'd5,  2'd3, 1'b0, BADINDEX};
    tbl[3] = '{4'd7,         32'd0,  2'd0, 1'b0, INVALID_OP};
    tbl[4] = '{4'd15,        32'd0,  2'd0, 1'b0, INVALID_OP};
    tbl[5] = '{LOCK,         32'hA5, 2'd0, 1'b1, CSTARTUNLOCKED};
    tbl[6] = '{UNLOCK,       32'd0,  2'd0, 1'b0, ALREADYUNLOCKED};
    tbl[7] = '{LOAD,         32'd77, 2'd1, 1'b0, NOERROR};
    tbl[8] = '{SETBIDCHARGE, 32'd1,  2'd0, 1'b0, NOERROR};

    reset_n = 1'b0;
    c_op = '0; c_data = '0; c_idx = '0; c_start = 1'b0;
    bid_vld = '0; bid_amt = '0; retract = '0;
    op8 = '0; data8 = '0; idx8 = '0; start8 = 1'b0; bv8 = '0; ba8 = '0; rt8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", c_ready, 1);
    chk("rst_err", c_err, 0);
    chk("rst_over", c_roundover, 0);
    chk("rst_maxbid", c_maxbid, 0);
    chk("rst_ack", bid_ack, 0);
    chk("rst_berr", bid_err, 0);
    chk("rst_win", bid_win, 0);
    chk("rst_balance", balance, 0);
    reset_n = 1'b1;
    tick();

    // command decode in UNLOCKED
    for (int k = 0; k < 9; k++) begin
      c_op = tbl[k].op; c_data = tbl[k].data; c_idx = tbl[k].idx; c_start = tbl[k].start;
      #1;
      chk($sformatf("tbl%0d_cerr", k), c_err, tbl[k].err);
      tick();
      c_op = NO_OP; c_data = '0; c_idx = '0; c_start = 1'b0;
    end
    chk("tbl_load1", bal_of(1), 77);
    chk("tbl_load_bad", bal_of(2), 0);

    // 1: basic round, same-cycle tie
    cmd(LOAD, 100, 0); cmd(LOAD, 50, 1); cmd(LOAD, 20, 2); cmd(LOCK, 32'hA5, 0);
    c_start = 1'b1; tick();
    bid_vld = 3'b111; bid_amt = {32'd10, 32'd30, 32'd30}; tick();
    bid_vld = '0;
    chk("t1_ack", bid_ack, 3'b111);
    chk("t1_berr", bid_err, 0);
    chk("t1_max", c_maxbid, 30);
    c_start = 1'b0; tick();
    chk("t1_over", c_roundover, 1);
    chk("t1_ready", c_ready, 0);
    tick();
    chk("t1_win", bid_win, 3'b001);
    chk("t1_bal0", bal_of(0), 69);
    chk("t1_bal1", bal_of(1), 49);
    chk("t1_bal2", bal_of(2), 19);
    chk("t1_maxhold", c_maxbid, 30);
    chk("t1_over_end", c_roundover, 0);

    // 2: equal later bid does not take the lead
    c_start = 1'b1; tick();
    chk("t2_win_clr", bid_win, 0);
    chk("t2_max_clr", c_maxbid, 0);
    bid_vld = 3'b010; bid_amt = {32'd0, 32'd40, 32'd0}; tick();
    chk("t2_ack1", bid_ack, 3'b010);
    bid_vld = 3'b001; bid_amt = {32'd0, 32'd0, 32'd40}; tick();
    bid_vld = '0;
    chk("t2_ack0", bid_ack, 3'b001);
    chk("t2_max", c_maxbid, 40);
    c_start = 1'b0; tick(); tick();
    chk("t2_win", bid_win, 3'b010);
    chk("t2_bal1", bal_of(1), 8);

    // 3: funds boundary, mask and inactive
    cmd(UNLOCK, 32'hA5, 0);
    cmd(LOAD, 20, 2); cmd(SETMASK, 3'b110, 0); cmd(SETTIMER, 3, 0); cmd(LOCK, 32'hA5, 0);
    bid_vld = 3'b010; bid_amt = {32'd0, 32'd1, 32'd0}; tick();
    chk("t3_inactive_ack", bid_ack, 0);
    chk("t3_inactive_err", bid_err, 6'b00_01_00);
    bid_vld = '0;
    c_start = 1'b1; tick();
    bid_vld = 3'b101; bid_amt = {32'd20, 32'd0, 32'd5}; tick();
    chk("t3_reject_ack", bid_ack, 0);
    chk("t3_reject_err", bid_err, 6'b11_00_10);
    bid_vld = 3'b100; bid_amt = {32'd19, 32'd0, 32'd0}; tick();
    bid_vld = '0;
    chk("t3_exact_ack", bid_ack, 3'b100);
    chk("t3_exact_bal", bal_of(2), 19);
    c_start = 1'b0; tick(); tick();
    chk("t3_win", bid_win, 3'b100);
    chk("t3_bal_end", bal_of(2), 0);

    // 4: bad key cooldown
    c_op = UNLOCK; c_data = 32'h5A; #1;
    chk("t4_locked_err", c_err, NOERROR);
    tick();
    c_op = UNLOCK; c_data = 32'hA5;
    chk("t4_cool0", c_err, BADKEY);
    tick();
    c_op = NO_OP; c_data = '0;
    chk("t4_cool1", c_err, BADKEY);
    tick();
    chk("t4_cool2", c_err, BADKEY);
    tick();
    chk("t4_locked_again", c_err, NOERROR);
    cmd(UNLOCK, 32'hA5, 0);
    c_op = UNLOCK; #1;
    chk("t4_unlocked", c_err, ALREADYUNLOCKED);
    c_op = NO_OP;

    // 5: retraction re-evaluates the leader
    cmd(LOAD, 100, 0); cmd(LOAD, 100, 1); cmd(LOAD, 100, 2);
    cmd(SETMASK, 3'b111, 0); cmd(LOCK, 32'hA5, 0);
    c_start = 1'b1; tick();
    bid_vld = 3'b111; bid_amt = {32'd40, 32'd30, 32'd50}; tick();
    bid_vld = '0;
    chk("t5_max50", c_maxbid, 50);
    retract = 3'b001; tick();
    chk("t5_max40", c_maxbid, 40);
    retract = 3'b110; tick();
    retract = '0;
    chk("t5_max0", c_maxbid, 0);
    c_start = 1'b0; tick(); tick();
    chk("t5_win", bid_win, 0);
    chk("t5_maxend", c_maxbid, 0);
    chk("t5_bal", balance, {32'd99, 32'd99, 32'd99});

    // 6: reset in the middle of a round
    c_start = 1'b1; tick();
    bid_vld = 3'b001; bid_amt = {32'd0, 32'd0, 32'd10}; tick();
    bid_vld = '0;
    chk("t6_ack", bid_ack, 3'b001);
    reset_n = 1'b0; c_start = 1'b0; #1;
    chk("t6_ready", c_ready, 1);
    chk("t6_err", c_err, 0);
    chk("t6_ack_rst", bid_ack, 0);
    chk("t6_max_rst", c_maxbid, 0);
    chk("t6_bal_rst", balance, 0);
    chk("t6_win_rst", bid_win, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // randomized rounds against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        m_bal[i] = $urandom_range(0, 120);
        cmd(LOAD, m_bal[i], 2'(i));
      end
      m_mask = 3'($urandom_range(1, 7));
      cmd(SETMASK, 32'(m_mask), 0);
      m_charge = $urandom_range(0, 3);
      cmd(SETBIDCHARGE, m_charge, 0);
      cmd(LOCK, 32'h1234, 0);
      c_start = 1'b1; tick();
      m_lvld = 0; m_max = 0; m_lead = 0;
      for (int i = 0; i < N; i++) begin m_stand[i] = 0; m_last[i] = 0; end
      for (int cyc = 0; cyc < 10; cyc++) begin
        for (int i = 0; i < N; i++) begin
          v[i]   = 1'($urandom_range(0, 1));
          amt[i] = (m_lvld && m_lead == i) ? m_max + $urandom_range(0, 5) : $urandom_range(0, 60);
          rt[i]  = !v[i] && ($urandom_range(0, 3) == 0);
          bid_vld[i] = v[i]; retract[i] = rt[i]; bid_amt[i*DW +: DW] = amt[i];
        end
        e_ack = '0; e_err = '0;
        for (int i = 0; i < N; i++) begin
          if (v[i]) begin
            if (!m_mask[i]) e_err[2*i +: 2] = MASKED;
            else if (longint'(amt[i]) + m_charge > m_bal[i]) e_err[2*i +: 2] = NOFUNDS;
            else e_ack[i] = 1'b1;
          end
        end
        retlead = m_lvld && rt[m_lead];
        for (int i = 0; i < N; i++) begin
          if (e_ack[i]) begin
            m_bal[i] -= m_charge; m_last[i] = amt[i]; m_stand[i] = 1;
          end else if (rt[i]) begin
            m_stand[i] = 0; m_last[i] = 0;
          end
        end
        if (retlead) begin
          m_lvld = 0; m_max = 0;
          for (int i = 0; i < N; i++)
            if (m_stand[i] && (!m_lvld || m_last[i] > m_max)) begin
              m_lvld = 1; m_lead = i; m_max = m_last[i];
            end
        end else begin
          for (int i = 0; i < N; i++)
            if (e_ack[i] && (!m_lvld || amt[i] > m_max)) begin
              m_lvld = 1; m_lead = i; m_max = amt[i];
            end
        end
        tick();
        chk($sformatf("rnd%0d_%0d_ack", r, cyc), bid_ack, e_ack);
        chk($sformatf("rnd%0d_%0d_err", r, cyc), bid_err, e_err);
        chk($sformatf("rnd%0d_%0d_max", r, cyc), c_maxbid, m_max);
        for (int i = 0; i < N; i++)
          chk($sformatf("rnd%0d_%0d_bal%0d", r, cyc, i), bal_of(i), m_bal[i]);
      end
      bid_vld = '0; retract = '0; c_start = 1'b0;
      tick();
      chk($sformatf("rnd%0d_over", r), c_roundover, 1);
      tick();
      e_win = '0;
      if (m_lvld) begin
        m_bal[m_lead] -= m_last[m_lead];
        e_win[m_lead] = 1'b1;
      end else begin
        m_max = 0;
      end
      chk($sformatf("rnd%0d_win", r), bid_win, e_win);
      chk($sformatf("rnd%0d_final_max", r), c_maxbid, m_max);
      for (int i = 0; i < N; i++)
        chk($sformatf("rnd%0d_final_bal%0d", r, i), bal_of(i), m_bal[i]);
      cmd(UNLOCK, 32'h1234, 0);
    end

    // NUMBIDDERS=8 rerun of the basic round
    cmd8(LOAD, 100, 0); cmd8(LOAD, 50, 1); cmd8(LOAD, 20, 2); cmd8(LOCK, 32'hA5, 0);
    start8 = 1'b1; tick();
    bv8 = 8'b0000_0111;
    ba8 = '0;
    ba8[0 +: DW] = 30; ba8[DW +: DW] = 30; ba8[2*DW +: DW] = 10;
    tick();
    bv8 = '0;
    chk("n8_ack", ack8, 8'b0000_0111);
    chk("n8_max", maxbid8, 30);
    start8 = 1'b0; tick(); tick();
    chk("n8_win", win8, 8'b0000_0001);
    chk("n8_bal0", bal8[0 +: DW], 69);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
